// File: rtl/cipu_pattern_driver_pkg.sv
// rtl/cipu_pattern_driver_pkg.sv - shared constants, enums and helpers for the CIPU pattern driver
// Purpose: framing characters, table-select and FSM state encodings, pointer saturation helper.
// Ports: none (package).
package cipu_pattern_driver_pkg;

  localparam logic [7:0] TERM = 8'h24;  // '$' end-of-stream marker
  localparam logic [7:0] SEP  = 8'h3b;  // ';' thing group separator

  typedef enum logic [1:0] {
    LD_PEOPLE = 2'd0,
    LD_THING  = 2'd1,
    LD_POP    = 2'd2
  } ld_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READY  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Clamp a pointer so it parks on the out-of-range slot instead of wrapping.
  function automatic int unsigned sat_ptr(int unsigned v, int unsigned lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/cipu_pattern_driver_if.sv
// rtl/cipu_pattern_driver_if.sv - load/start/stream bundle between the pattern driver and its peers
// Purpose: groups table-load, start, CIPU ready/stream outputs and done_thing handshake.
// Ports (members): load_en, load_sel, load_addr, load_data, start, done_thing (into driver);
//   ready_fifo, ready_lifo, people_thing_in, thing_in, thing_num, busy, stream_done (out of driver).
interface cipu_pattern_driver_if
  import cipu_pattern_driver_pkg::*;
#(
  parameter int AW = 6,
  parameter int W  = 8,
  parameter int NW = 4
);
  logic          load_en;
  ld_sel_e       load_sel;
  logic [AW-1:0] load_addr;
  logic [W-1:0]  load_data;
  logic          start;
  logic          done_thing;
  logic          ready_fifo;
  logic          ready_lifo;
  logic [W-1:0]  people_thing_in;
  logic [W-1:0]  thing_in;
  logic [NW-1:0] thing_num;
  logic          busy;
  logic          stream_done;

  modport master (
    input  load_en, load_sel, load_addr, load_data, start, done_thing,
    output ready_fifo, ready_lifo, people_thing_in, thing_in, thing_num, busy, stream_done
  );

  modport slave (
    output load_en, load_sel, load_addr, load_data, start, done_thing,
    input  ready_fifo, ready_lifo, people_thing_in, thing_in, thing_num, busy, stream_done
  );
endinterface

// File: rtl/cipu_pattern_driver_pat_rom.sv
// rtl/cipu_pattern_driver_pat_rom.sv - pattern table: sync write, two async reads
// Purpose: DEPTH x W storage; reads at index >= DEPTH return OOR, writes there are dropped.
// Ports: clk; i_we/i_waddr/i_wdata write port; i_raddr_a/i_raddr_b -> o_rdata_a/o_rdata_b.
module cipu_pat_rom #(
  parameter int             DEPTH = 50,
  parameter int             AW    = 6,
  parameter int             W     = 8,
  parameter logic [W-1:0]   OOR   = '0
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [W-1:0]  o_rdata_a,
  output logic [W-1:0]  o_rdata_b
);
  // Contents are intentionally not reset so tables survive a driver reset.
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we && (i_waddr < AW'(DEPTH))) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a < AW'(DEPTH)) ? r_mem[i_raddr_a] : OOR;
  assign o_rdata_b = (i_raddr_b < AW'(DEPTH)) ? r_mem[i_raddr_b] : OOR;
endmodule

// File: rtl/cipu_pattern_driver.sv
// rtl/cipu_pattern_driver.sv - CIPU self-test stimulus transmitter (people + thing streams)
// Purpose: loads people/thing/pop tables in IDLE, then on start pulses ready and streams both
//   tables into CIPU, stepping thing groups on done_thing, parking on '$'.
// Ports: clk, rst (sync active-high); bus (master modport of cipu_pattern_driver_if).
module cipu_pattern_driver
  import cipu_pattern_driver_pkg::*;
#(
  parameter int DEPTH = 50,
  parameter int AW    = 6,
  parameter int W     = 8,
  parameter int NW    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  cipu_pattern_driver_if.master  bus
);
  localparam logic [W-1:0] L_TERM = W'(TERM);
  localparam logic [W-1:0] L_SEP  = W'(SEP);

  state_e        r_state;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_people;
  logic [W-1:0]  r_thing;
  logic [NW-1:0] r_num;
  logic [AW-1:0] r_pp_ptr;
  logic [AW-1:0] r_th_ptr;
  logic [AW-1:0] r_pop_ptr;

  logic          w_load_ok;
  logic [W-1:0]  w_p_cur;
  logic [W-1:0]  w_p_unused;
  logic [W-1:0]  w_t_cur;
  logic [W-1:0]  w_t_nxt;
  logic [NW-1:0] w_n_cur;
  logic [NW-1:0] w_n_nxt;

  assign w_load_ok = bus.load_en && (r_state == ST_IDLE);

  cipu_pat_rom #(.DEPTH(DEPTH), .AW(AW), .W(W), .OOR(L_TERM)) u_people (
    .clk      (clk),
    .i_we     (w_load_ok && (bus.load_sel == LD_PEOPLE)),
    .i_waddr  (bus.load_addr),
    .i_wdata  (bus.load_data),
    .i_raddr_a(r_pp_ptr),
    .i_raddr_b(r_pp_ptr),
    .o_rdata_a(w_p_cur),
    .o_rdata_b(w_p_unused)
  );

  cipu_pat_rom #(.DEPTH(DEPTH), .AW(AW), .W(W), .OOR(L_TERM)) u_thing (
    .clk      (clk),
    .i_we     (w_load_ok && (bus.load_sel == LD_THING)),
    .i_waddr  (bus.load_addr),
    .i_wdata  (bus.load_data),
    .i_raddr_a(r_th_ptr),
    .i_raddr_b(r_th_ptr + AW'(1)),
    .o_rdata_a(w_t_cur),
    .o_rdata_b(w_t_nxt)
  );

  cipu_pat_rom #(.DEPTH(DEPTH), .AW(AW), .W(NW), .OOR('0)) u_pop (
    .clk      (clk),
    .i_we     (w_load_ok && (bus.load_sel == LD_POP)),
    .i_waddr  (bus.load_addr),
    .i_wdata  (bus.load_data[NW-1:0]),
    .i_raddr_a(r_pop_ptr),
    .i_raddr_b(r_pop_ptr + AW'(1)),
    .o_rdata_a(w_n_cur),
    .o_rdata_b(w_n_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_people  <= '0;
      r_thing   <= '0;
      r_num     <= '0;
      r_pp_ptr  <= '0;
      r_th_ptr  <= '0;
      r_pop_ptr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_READY: begin
          r_ready <= 1'b0;
          r_state <= ST_STREAM;
        end
        ST_STREAM: begin
          // People stream: emit current char, advance unless parked on '$'.
          r_people <= w_p_cur;
          if (w_p_cur != L_TERM) begin
            r_pp_ptr <= AW'(sat_ptr(32'(r_pp_ptr) + 32'd1, DEPTH));
          end
          // Thing stream: a ';' is held until CIPU reports the group consumed.
          if (w_t_cur == L_TERM) begin
            // parked: outputs hold
          end else if (w_t_cur != L_SEP) begin
            r_thing  <= w_t_cur;
            r_num    <= w_n_cur;
            r_th_ptr <= AW'(sat_ptr(32'(r_th_ptr) + 32'd1, DEPTH));
          end else if (!bus.done_thing) begin
            r_thing <= L_SEP;
            r_num   <= w_n_cur;
          end else begin
            r_num     <= w_n_nxt;
            r_pop_ptr <= AW'(sat_ptr(32'(r_pop_ptr) + 32'd1, DEPTH));
            if (w_t_nxt != L_SEP) begin
              // Skip over the separator straight to the next group's first char.
              r_thing  <= w_t_nxt;
              r_th_ptr <= AW'(sat_ptr(32'(r_th_ptr) + 32'd2, DEPTH));
            end else begin
              // Empty group: land on the second ';' and wait for the next done.
              r_thing  <= L_SEP;
              r_th_ptr <= AW'(sat_ptr(32'(r_th_ptr) + 32'd1, DEPTH));
            end
          end
          if ((w_p_cur == L_TERM) && (w_t_cur == L_TERM)) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          // Holds until reset.
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready_fifo      = r_ready;
  assign bus.ready_lifo      = r_ready;
  assign bus.people_thing_in = r_people;
  assign bus.thing_in        = r_thing;
  assign bus.thing_num       = r_num;
  assign bus.busy            = r_busy;
  assign bus.stream_done     = r_done;
endmodule

// File: tb/tb_cipu_pattern_driver.sv
// tb/tb_cipu_pattern_driver.sv - directed self-checking bench for cipu_pattern_driver
module tb_cipu_pattern_driver;
  import cipu_pattern_driver_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cipu_pattern_driver_if #(.AW(6), .W(8), .NW(4)) bus ();

  cipu_pattern_driver #(.DEPTH(50), .AW(6), .W(8), .NW(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input ld_sel_e sel, input int addr, input logic [7:0] data);
    bus.load_en   = 1'b1;
    bus.load_sel  = sel;
    bus.load_addr = 6'(addr);
    bus.load_data = data;
    tick();
    bus.load_en   = 1'b0;
  endtask

  task automatic chk_stream(input string tag, input logic [7:0] p, input logic [7:0] t,
                            input logic [3:0] n);
    chk({tag, "_people"}, 32'(bus.people_thing_in), 32'(p));
    chk({tag, "_thing"},  32'(bus.thing_in),        32'(t));
    chk({tag, "_num"},    32'(bus.thing_num),       32'(n));
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.load_en   = 1'b0;
    bus.load_sel  = LD_PEOPLE;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.start     = 1'b0;
    bus.done_thing = 1'b0;

    // Reset / idle
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("idle_ready_fifo", 32'(bus.ready_fifo), 32'd0);
    chk("idle_ready_lifo", 32'(bus.ready_lifo), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done", 32'(bus.stream_done), 32'd0);
    chk_stream("idle", 8'h00, 8'h00, 4'd0);

    // Scenario A: people 41,42,43,$ ; thing single separators
    load(LD_PEOPLE, 0, 8'h41); load(LD_PEOPLE, 1, 8'h42);
    load(LD_PEOPLE, 2, 8'h43); load(LD_PEOPLE, 3, 8'h24);
    load(LD_THING, 0, 8'h41); load(LD_THING, 1, 8'h3b); load(LD_THING, 2, 8'h42);
    load(LD_THING, 3, 8'h3b); load(LD_THING, 4, 8'h24); load(LD_THING, 5, 8'h24);
    load(LD_POP, 0, 8'd2); load(LD_POP, 1, 8'd3); load(LD_POP, 2, 8'd5);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("a_ready_fifo", 32'(bus.ready_fifo), 32'd1);
    chk("a_ready_lifo", 32'(bus.ready_lifo), 32'd1);
    chk("a_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("a_ready_drop", 32'(bus.ready_fifo), 32'd0);
    tick();
    chk_stream("a_e2", 8'h41, 8'h41, 4'd2);
    tick();
    chk_stream("a_e3", 8'h42, 8'h3b, 4'd2);
    tick();
    chk_stream("a_e4", 8'h43, 8'h3b, 4'd2);
    bus.done_thing = 1'b1;
    tick();
    bus.done_thing = 1'b0;
    chk_stream("a_e5", 8'h24, 8'h42, 4'd3);
    // Load attempt during STREAM must be ignored (P[3] is the parked slot).
    bus.load_en = 1'b1; bus.load_sel = LD_PEOPLE; bus.load_addr = 6'd3; bus.load_data = 8'h55;
    tick();
    chk_stream("a_e6", 8'h24, 8'h3b, 4'd3);
    bus.load_sel = LD_THING; bus.load_addr = 6'd3; bus.load_data = 8'h41;
    tick();
    bus.load_en = 1'b0;
    chk_stream("a_e7", 8'h24, 8'h3b, 4'd3);
    bus.done_thing = 1'b1;
    tick();
    bus.done_thing = 1'b0;
    chk_stream("a_e8", 8'h24, 8'h24, 4'd5);
    chk("a_e8_done", 32'(bus.stream_done), 32'd0);
    chk("a_e8_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("a_e9_done", 32'(bus.stream_done), 32'd1);
    chk("a_e9_busy", 32'(bus.busy), 32'd0);
    chk_stream("a_e9", 8'h24, 8'h24, 4'd5);
    bus.start = 1'b1; bus.done_thing = 1'b1;
    tick();
    bus.start = 1'b0; bus.done_thing = 1'b0;
    tick();
    chk("a_hold_ready", 32'(bus.ready_fifo), 32'd0);
    chk("a_hold_done", 32'(bus.stream_done), 32'd1);
    chk_stream("a_hold", 8'h24, 8'h24, 4'd5);

    // Reset out of DONE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_done", 32'(bus.stream_done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk_stream("rst", 8'h00, 8'h00, 4'd0);

    // Scenario B: double separator, load+start in the same cycle
    load(LD_THING, 0, 8'h41); load(LD_THING, 1, 8'h3b); load(LD_THING, 2, 8'h3b);
    load(LD_THING, 3, 8'h42); load(LD_THING, 4, 8'h24); load(LD_THING, 5, 8'h24);
    load(LD_POP, 0, 8'd1); load(LD_POP, 1, 8'd4); load(LD_POP, 2, 8'd6);
    load(LD_PEOPLE, 1, 8'h24);
    bus.start = 1'b1;
    load(LD_PEOPLE, 0, 8'h50);
    bus.start = 1'b0;
    chk("b_ready", 32'(bus.ready_fifo), 32'd1);
    tick();
    tick();
    chk_stream("b_e2", 8'h50, 8'h41, 4'd1);
    tick();
    chk_stream("b_e3", 8'h24, 8'h3b, 4'd1);
    bus.done_thing = 1'b1;
    tick();
    bus.done_thing = 1'b0;
    chk_stream("b_e4", 8'h24, 8'h3b, 4'd4);
    tick();
    chk_stream("b_e5", 8'h24, 8'h3b, 4'd4);
    chk("b_e5_done", 32'(bus.stream_done), 32'd0);
    bus.done_thing = 1'b1;
    tick();
    bus.done_thing = 1'b0;
    chk_stream("b_e6", 8'h24, 8'h42, 4'd6);
    tick();
    chk("b_e7_done", 32'(bus.stream_done), 32'd1);
    chk_stream("b_e7", 8'h24, 8'h42, 4'd6);

    // Reset mid-STREAM then replay
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("c_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("c_rst_busy", 32'(bus.busy), 32'd0);
    chk("c_rst_ready", 32'(bus.ready_fifo), 32'd0);
    chk_stream("c_rst", 8'h00, 8'h00, 4'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk_stream("c_replay", 8'h50, 8'h41, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
